// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared 7-segment definitions for display blocks.
//   bcd_t       : one BCD digit (4 bits)
//   SEG_BLANK   : all segments off (active-high encoding)
//   SEG_DASH    : middle bar only, shown for invalid digits
//   SEG_TABLE   : segment patterns {g,f,e,d,c,b,a} for digits 0..9
// ---------------------------------------------------------------------------
package seg7_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    // Entry [d] is the active-high pattern for digit d.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage : seg7_pkg

// File: rtl/bcd_to_seg7.sv
// ---------------------------------------------------------------------------
// bcd_to_seg7
// Purely combinational BCD to 7-segment decoder (active-high segments).
// Values 10..15 decode to a dash.
// Ports:
//   bcd_i  in  4  BCD digit
//   seg_o  out 7  segments {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Table lookup for legal digits, dash for anything above nine.
    always_comb begin
        seg_o = SEG_DASH;
        if (bcd_i <= 4'd9) begin
            seg_o = SEG_TABLE[bcd_i];
        end else begin
            seg_o = SEG_DASH;
        end
    end

endmodule : bcd_to_seg7

// File: rtl/bcd_seg_scan.sv
// ---------------------------------------------------------------------------
// bcd_seg_scan
// Time-multiplexed common-select 7-segment driver for a packed BCD count.
// A pending buffer captures bcd on load; the shadow buffer that feeds the
// display only changes at the frame boundary, so a frame is never torn.
// The last clock of every digit slot is blanked to avoid ghosting.
//
// Parameters:
//   DIGITS         number of digits / display positions (1..8)
//   PRESCALE       clk cycles per digit slot (>= 2)
//   SEG_ACTIVE_LOW 1 inverts seg (dig_sel stays active-high)
// Optional build macro:
//   LEAD_ZERO_BLANK_EN  blank digits above the most-significant nonzero
//                       shadow digit (digit 0 always shown)
// Ports:
//   clk      in   1         system clock
//   rst      in   1         synchronous active-high reset
//   bcd      in   4*DIGITS  packed BCD, digit 0 in [3:0]
//   load     in   1         capture bcd into pending buffer
//   seg      out  7         segments {g,f,e,d,c,b,a}, registered
//   dig_sel  out  DIGITS    one-hot digit enable, registered
//   frame    out  1         one-cycle pulse after each full scan
//   err      out  1         sticky invalid-BCD flag
// ---------------------------------------------------------------------------
module bcd_seg_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int PRESCALE       = 1000,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame,
    output logic                  err
);

    localparam int PW    = $clog2(PRESCALE);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [6:0]       SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;

    // True when any nibble of a packed word is outside 0..9.
    function automatic logic has_invalid(input logic [4*DIGITS-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            bad = bad | (v[4*i +: 4] > 4'd9);
        end
        return bad;
    endfunction

    logic [PW-1:0]         prescale_q, prescale_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*DIGITS-1:0]   pending_q, pending_d;
    logic [4*DIGITS-1:0]   shadow_q, shadow_d;
    logic                  err_q, err_d;
    logic                  frame_q, frame_d;
    logic [6:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     dig_q, dig_d;

    logic                  slot_end_s;
    logic                  boundary_s;
    logic [3:0]            cur_digit_s;
    logic [6:0]            dec_seg_s;
    logic [DIGITS-1:0]     lz_blank_s;

    assign cur_digit_s = shadow_q[{idx_q, 2'b00} +: 4];

    bcd_to_seg7 u_dec (
        .bcd_i (cur_digit_s),
        .seg_o (dec_seg_s)
    );

`ifdef LEAD_ZERO_BLANK_EN
    // Walk from the top digit down; a digit is blank until a nonzero
    // (or invalid) digit has been seen at or above it. Digit 0 never blanks.
    always_comb begin
        logic nz_seen;
        nz_seen    = 1'b0;
        lz_blank_s = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nz_seen       = nz_seen | (shadow_q[4*i +: 4] != 4'd0);
            lz_blank_s[i] = ~nz_seen & (i != 0);
        end
    end
`else
    assign lz_blank_s = '0;
`endif

    // Next-state logic for scan counters, buffers and output registers.
    always_comb begin
        slot_end_s = (prescale_q == PRE_LAST);
        boundary_s = slot_end_s && (idx_q == IDX_LAST);

        if (slot_end_s) begin
            prescale_d = '0;
            idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
            prescale_d = prescale_q + PW'(1);
            idx_d      = idx_q;
        end

        pending_d = load ? bcd : pending_q;

        // On the boundary edge a simultaneous load bypasses pending.
        if (boundary_s) begin
            shadow_d = load ? bcd : pending_q;
            err_d    = err_q | has_invalid(shadow_d);
        end else begin
            shadow_d = shadow_q;
            err_d    = err_q;
        end

        frame_d = boundary_s;

        if (slot_end_s) begin
            dig_d = '0;
            seg_d = SEG_BLANK;
        end else begin
            dig_d = DIGITS'(1'b1) << idx_q;
            seg_d = lz_blank_s[idx_q] ? SEG_BLANK : dec_seg_s;
        end

        if (SEG_ACTIVE_LOW != 0) begin
            seg_d = ~seg_d;
        end else begin
            seg_d = seg_d;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescale_q <= '0;
            idx_q      <= '0;
            pending_q  <= '0;
            shadow_q   <= '0;
            err_q      <= 1'b0;
            frame_q    <= 1'b0;
            seg_q      <= SEG_OFF;
            dig_q      <= '0;
        end else begin
            prescale_q <= prescale_d;
            idx_q      <= idx_d;
            pending_q  <= pending_d;
            shadow_q   <= shadow_d;
            err_q      <= err_d;
            frame_q    <= frame_d;
            seg_q      <= seg_d;
            dig_q      <= dig_d;
        end
    end

    assign seg     = seg_q;
    assign dig_sel = dig_q;
    assign frame   = frame_q;
    assign err     = err_q;

endmodule : bcd_seg_scan

// File: tb/tb_bcd_seg_scan.sv
module tb_bcd_seg_scan;

    localparam int D  = 4;
    localparam int P  = 4;
    localparam int FL = P * D;   // cycles per frame

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bcd = 16'h0000;
    logic        load = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  dig_sel;
    logic        frame;
    logic        err;

    int total = 0;
    int bad   = 0;

    bcd_seg_scan #(.DIGITS(D), .PRESCALE(P), .SEG_ACTIVE_LOW(0)) dut (
        .clk(clk), .rst(rst), .bcd(bcd), .load(load),
        .seg(seg), .dig_sel(dig_sel), .frame(frame), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: display state as seen by the viewer.
    logic [6:0]  seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                   7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    int          n;            // non-reset edges since reset
    logic [15:0] m_pend, m_shad;
    logic        m_err;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_dig;
    logic        exp_frame, exp_err;

    function automatic logic m_invalid(input logic [15:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) r = 1'b1;
        return r;
    endfunction

    function automatic logic [6:0] m_seg(input logic [15:0] v, input int slot);
        logic [3:0] d;
        logic [6:0] s;
        d = v[4*slot +: 4];
        s = (d > 4'd9) ? 7'h40 : seg_tab[d];
`ifdef LEAD_ZERO_BLANK_EN
        if (slot > 0 && (v >> (4*slot)) == 16'h0000) s = 7'h00;
`endif
        return s;
    endfunction

    // One clock: drive inputs, advance the model, leave expectations set.
    task automatic tick(input logic r, input logic ld, input logic [15:0] b);
        int pos, slot;
        rst = r; load = ld; bcd = b;
        @(posedge clk);
        #1;
        if (r) begin
            n = 0; m_pend = 16'h0; m_shad = 16'h0; m_err = 1'b0;
            exp_seg = 7'h00; exp_dig = 4'h0; exp_frame = 1'b0; exp_err = 1'b0;
        end else begin
            pos  = n % P;
            slot = (n / P) % D;
            if (pos == P - 1) begin
                exp_dig = 4'h0;
                exp_seg = 7'h00;
            end else begin
                exp_dig = 4'(1 << slot);
                exp_seg = m_seg(m_shad, slot);
            end
            exp_frame = ((n % FL) == FL - 1);
            if (exp_frame) begin
                m_shad = ld ? b : m_pend;
                if (m_invalid(m_shad)) m_err = 1'b1;
            end
            if (ld) m_pend = b;
            exp_err = m_err;
            n++;
        end
    endtask

    // Idle until the next edge will be edge number t within the frame.
    task automatic run_to(input int t);
        for (int k = 0; k < FL && (n % FL) != t; k++) tick(1'b0, 1'b0, 16'h0);
    endtask

    task automatic test_reset;
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b1, 16'h1234);
            total++;
            if (seg !== 7'h00 || dig_sel !== 4'h0 || err !== 1'b0 || frame !== 1'b0) begin
                bad++;
                $display("FAIL reset: seg=%h dig=%b err=%b frame=%b want 00/0000/0/0", seg, dig_sel, err, frame);
            end
        end
        tick(1'b0, 1'b0, 16'h0);
        total++;
        if (seg !== 7'h3F || dig_sel !== 4'b0001) begin
            bad++;
            $display("FAIL first_lit: seg=%h dig=%b want 3f/0001", seg, dig_sel);
        end
    endtask

    task automatic test_scan;
        int frames;
        tick(1'b0, 1'b1, 16'h1234);
        run_to(0);
        frames = 0;
        for (int k = 0; k < 2 * FL; k++) begin
            tick(1'b0, 1'b0, 16'h0);
            if (frame === 1'b1) frames++;
            total++;
            if (seg !== exp_seg || dig_sel !== exp_dig || frame !== exp_frame || err !== exp_err) begin
                bad++;
                $display("FAIL scan: seg=%h dig=%b frame=%b err=%b want %h/%b/%b/%b",
                         seg, dig_sel, frame, err, exp_seg, exp_dig, exp_frame, exp_err);
            end
        end
        total++;
        if (frames != 2) begin
            bad++;
            $display("FAIL frame_count: got %0d want 2", frames);
        end
    endtask

    task automatic test_midframe;
        run_to(6);
        tick(1'b0, 1'b1, 16'h5678);
        for (int k = 0; k < 2 * FL; k++) begin
            tick(1'b0, 1'b0, 16'h0);
            total++;
            if (seg !== exp_seg || dig_sel !== exp_dig || frame !== exp_frame) begin
                bad++;
                $display("FAIL midframe: seg=%h dig=%b frame=%b want %h/%b/%b",
                         seg, dig_sel, frame, exp_seg, exp_dig, exp_frame);
            end
        end
    endtask

    task automatic test_back_to_back;
        run_to(2);
        tick(1'b0, 1'b1, 16'h1111);
        run_to(FL - 1);
        tick(1'b0, 1'b1, 16'h9999);   // boundary edge: bypass into shadow
        for (int k = 0; k < FL; k++) begin
            tick(1'b0, 1'b0, 16'h0);
            total++;
            if (seg !== exp_seg || dig_sel !== exp_dig ||
                (dig_sel !== 4'h0 && seg !== 7'h6F)) begin
                bad++;
                $display("FAIL bypass: seg=%h dig=%b want %h/%b (lit=6f)", seg, dig_sel, exp_seg, exp_dig);
            end
        end
    endtask

    task automatic test_err;
        tick(1'b0, 1'b1, 16'h00A3);
        run_to(FL - 1);
        tick(1'b0, 1'b0, 16'h0);
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL err_set: err=%b want 1", err);
        end
        tick(1'b0, 1'b1, 16'h0001);
        for (int k = 0; k < 2 * FL; k++) begin
            tick(1'b0, 1'b0, 16'h0);
            total++;
            if (seg !== exp_seg || dig_sel !== exp_dig || err !== 1'b1) begin
                bad++;
                $display("FAIL err_sticky: seg=%h dig=%b err=%b want %h/%b/1", seg, dig_sel, err, exp_seg, exp_dig);
            end
        end
    endtask

    task automatic test_random;
        logic        r, ld;
        logic [15:0] b;
        for (int k = 0; k < 400; k++) begin
            r  = ($urandom_range(0, 79) == 0);
            ld = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < D; i++)
                b[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                           : 4'($urandom_range(0, 9));
            tick(r, ld, b);
            total++;
            if (seg !== exp_seg || dig_sel !== exp_dig || frame !== exp_frame || err !== exp_err) begin
                bad++;
                $display("FAIL random: seg=%h dig=%b frame=%b err=%b want %h/%b/%b/%b",
                         seg, dig_sel, frame, err, exp_seg, exp_dig, exp_frame, exp_err);
            end
        end
    endtask

`ifdef LEAD_ZERO_BLANK_EN
    task automatic test_lead_zero;
        tick(1'b1, 1'b0, 16'h0);
        tick(1'b0, 1'b1, 16'h0070);
        run_to(FL - 1);
        tick(1'b0, 1'b0, 16'h0);
        for (int k = 0; k < FL; k++) begin
            tick(1'b0, k == 0, 16'h0000);
            total++;
            if (seg !== exp_seg || dig_sel !== exp_dig ||
                ((dig_sel == 4'b1000 || dig_sel == 4'b0100) && seg !== 7'h00)) begin
                bad++;
                $display("FAIL lzb_0070: seg=%h dig=%b want %h/%b", seg, dig_sel, exp_seg, exp_dig);
            end
        end
        for (int k = 0; k < FL; k++) begin
            tick(1'b0, 1'b0, 16'h0);
            total++;
            if (seg !== exp_seg || dig_sel !== exp_dig ||
                (dig_sel != 4'b0001 && seg !== 7'h00)) begin
                bad++;
                $display("FAIL lzb_0000: seg=%h dig=%b want %h/%b", seg, dig_sel, exp_seg, exp_dig);
            end
        end
    endtask
`endif

    initial begin
        n = 0; m_pend = 16'h0; m_shad = 16'h0; m_err = 1'b0;
        test_reset();
        test_scan();
        test_midframe();
        test_back_to_back();
        test_err();
        test_random();
`ifdef LEAD_ZERO_BLANK_EN
        test_lead_zero();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bcd_seg_scan
